corefifo_rd_ctrl: RTL and testbench
===================================

Name: corefifo_rd_ctrl

Overview:
- Read-side pointer and flag controller for the dual-clock COREFIFO; runs entirely in the read clock domain.
- Synchronizes the Gray-coded write pointer, converts it to binary, and maintains the binary/Gray read pointer.
- Generates memory read strobe/address, empty/almost-empty flags, fill count, data-valid and underflow.
- The Gray read pointer it exports feeds the write-side controller's synchronizer.

Parameters:
- ADDRWIDTH, 3, memory address width; depth = 2^ADDRWIDTH; pointers are ADDRWIDTH+1 bits.
- AEVAL, 2, almost-empty threshold; legal range 1 to 2^ADDRWIDTH-1.
- SYNC_STAGES, 2, flop stages on wptr_gray_in; minimum 2.

Ports:
- clk  in  1  read clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- re  in  1  read request.
- wptr_gray_in  in  ADDRWIDTH+1  write pointer, Gray, asynchronous to clk.
- rptr_gray_out  out  ADDRWIDTH+1  read pointer, Gray, registered.
- raddr  out  ADDRWIDTH  memory read address = rptr_bin[ADDRWIDTH-1:0].
- mem_re  out  1  memory read enable (combinational).
- empty  out  1  FIFO empty, registered.
- aempty  out  1  almost empty, registered.
- rd_cnt  out  ADDRWIDTH+1  entries available, registered.
- dvld  out  1  memory read data valid.
- underflow  out  1  one-cycle pulse on rejected read.

Behaviour:
- Reset: reset_n=0 at an edge clears sync flops, rptr_bin, rptr_gray_out, rd_cnt, dvld and underflow to 0, and sets empty=1, aempty=1. Applies mid-operation, overriding re; write side is reset together.
- Sync: SYNC_STAGES cascaded flops on wptr_gray_in. wbin = combinational Gray-to-binary of the last stage: MSB copied; bit i = bit i+1 XOR gray bit i.
- Read accept: rd_ok = re & ~empty. mem_re = rd_ok. raddr = current rptr_bin low bits.
- rptr_next = rptr_bin + rd_ok, modulo 2^(ADDRWIDTH+1); wraps all-ones to 0.
- rptr_gray_out <= rptr_next ^ (rptr_next >> 1); updates on the same edge as rptr_bin.
- cnt_next = (wbin - rptr_next) modulo 2^(ADDRWIDTH+1). Legal range 0 to 2^ADDRWIDTH.
- Registered outputs: rd_cnt <= cnt_next; empty <= (cnt_next==0); aempty <= (cnt_next <= AEVAL).
- Last-entry read: empty asserts on the accepting edge itself; no read past the last entry is possible.
- dvld <= rd_ok: one-cycle memory latency, so data for an accepted read is valid the following cycle.
- underflow <= re & empty. The rejected read leaves pointers and flags unchanged.
- Write visibility latency: a wptr_gray_in change stable before edge 1 updates empty/rd_cnt at edge SYNC_STAGES+1 (edge 3 by default). Flags are pessimistic, never optimistic.
- Simultaneous accepted read and synchronized write increment: rd_cnt unchanged; empty stays 0.
- Gray input with multiple bits changing is illegal. The converter decodes it without protection; the bench asserts single-bit change per write step.

Test Plan:
- Reset: reset_n=0 for 3 cycles with wptr_gray_in=0000, re=1 → after release empty=1, aempty=1, rd_cnt=0, rptr_gray_out=0000, mem_re=0, dvld=0.
- Latency (defaults): wptr_gray_in 0000→0001 just before edge 1 → empty=0, rd_cnt=1, aempty=1 at edge 3, not earlier.
- Fill/drain: step wptr_gray_in through Gray of 1..8, ending at 1100 → rd_cnt=8, aempty=0. Then hold re=1 for 9 cycles → raddr 0..7, mem_re high 8 cycles, dvld high 8 cycles lagging by 1, empty=1 on 8th accepting edge, rptr_gray_out=1100, 9th request gives underflow=1 for one cycle.
- Wrap: continue writes/reads until rptr_bin passes 15 → rptr_gray_out 1000→0000, raddr 7→0, rd_cnt correct across the wrap.
- Simultaneous: rd_cnt=3, re=1 on the edge where synchronized wbin increments → rd_cnt stays 3; aempty is unchanged.
- Reset mid-read: rd_cnt=5, re=1, reset_n=0 for one edge → all outputs at reset values next cycle, no mem_re during reset.

Source files
------------

// File: rtl/corefifo_rd_ctrl.sv
// Read-side pointer/flag controller for a dual-clock FIFO: synchronizes the Gray write
// pointer into the read domain and owns the read pointer, empty flags and fill count.
module corefifo_rd_ctrl #(
  parameter int ADDRWIDTH   = 3,
  parameter int AEVAL       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 re,
  input  logic [ADDRWIDTH:0]   wptr_gray_in,
  output logic [ADDRWIDTH:0]   rptr_gray_out,
  output logic [ADDRWIDTH-1:0] raddr,
  output logic                 mem_re,
  output logic                 empty,
  output logic                 aempty,
  output logic [ADDRWIDTH:0]   rd_cnt,
  output logic                 dvld,
  output logic                 underflow
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEVAL);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rptr_bin_q, rptr_bin_d;
  logic [PW-1:0] rptr_gray_q;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          empty_q, aempty_q, dvld_q, underflow_q;
  logic          rd_ok;

  // Synchronizer stage 0 samples the asynchronous pointer; the last stage feeds the decoder.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], wptr_gray_in};
    end
  end

  // Reads are gated by reset so no memory access escapes while the pointers are being cleared.
  always_comb begin
    wbin       = gray2bin(sync_q[SYNC_STAGES-1]);
    rd_ok      = re & ~empty_q & reset_n;
    rptr_bin_d = rptr_bin_q + {{ADDRWIDTH{1'b0}}, rd_ok};
    cnt_d      = wbin - rptr_bin_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
      cnt_q       <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      dvld_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= bin2gray(rptr_bin_d);
      cnt_q       <= cnt_d;
      empty_q     <= (cnt_d == '0);
      aempty_q    <= (cnt_d <= AE_TH);
      dvld_q      <= rd_ok;
      underflow_q <= re & empty_q;
    end
  end

  assign rptr_gray_out = rptr_gray_q;
  assign raddr         = rptr_bin_q[ADDRWIDTH-1:0];
  assign mem_re        = rd_ok;
  assign empty         = empty_q;
  assign aempty        = aempty_q;
  assign rd_cnt        = cnt_q;
  assign dvld          = dvld_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_corefifo_rd_ctrl.sv
// Scoreboard bench for corefifo_rd_ctrl: the driver models the FIFO as write/read counts
// plus a write-visibility delay, and a negedge monitor compares the DUT against the queue.
module tb_corefifo_rd_ctrl;

  localparam int AW = 3;
  localparam int AEV = 2;
  localparam int SS = 2;
  localparam int PW = AW + 1;

  logic          clk;
  logic          reset_n;
  logic          re;
  logic [PW-1:0] wptr_gray_in;
  logic [PW-1:0] rptr_gray_out;
  logic [AW-1:0] raddr;
  logic          mem_re;
  logic          empty;
  logic          aempty;
  logic [PW-1:0] rd_cnt;
  logic          dvld;
  logic          underflow;

  corefifo_rd_ctrl #(.ADDRWIDTH(AW), .AEVAL(AEV), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .re(re), .wptr_gray_in(wptr_gray_in),
    .rptr_gray_out(rptr_gray_out), .raddr(raddr), .mem_re(mem_re), .empty(empty),
    .aempty(aempty), .rd_cnt(rd_cnt), .dvld(dvld), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic mem_re;
    logic [AW-1:0] raddr;
    logic empty;
    logic aempty;
    logic [PW-1:0] rd_cnt;
    logic [PW-1:0] rptr_gray;
    logic dvld;
    logic uf;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int failed = 0;
  int cyc = 0;

  // Reference model: counts since the last reset, plus the inputs seen by the sync chain.
  int wr = 0;
  int m_reads = 0;
  int m_cnt = 0;
  bit m_empty = 1'b1;
  bit m_aempty = 1'b1;
  bit m_dvld = 1'b0;
  bit m_uf = 1'b0;
  int pipe[$];
  logic [PW-1:0] prev_g = '0;

  function automatic logic [PW-1:0] gray(input int x);
    logic [PW-1:0] b;
    b = PW'(x % (1 << PW));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] xp);
    tests++;
    if (act !== xp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, xp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("mem_re", e.cyc, 32'(mem_re), 32'(e.mem_re));
      chk("raddr", e.cyc, 32'(raddr), 32'(e.raddr));
      chk("empty", e.cyc, 32'(empty), 32'(e.empty));
      chk("aempty", e.cyc, 32'(aempty), 32'(e.aempty));
      chk("rd_cnt", e.cyc, 32'(rd_cnt), 32'(e.rd_cnt));
      chk("rptr_gray_out", e.cyc, 32'(rptr_gray_out), 32'(e.rptr_gray));
      chk("dvld", e.cyc, 32'(dvld), 32'(e.dvld));
      chk("underflow", e.cyc, 32'(underflow), 32'(e.uf));
    end
  end

  task automatic reset_model();
    m_reads = 0;
    m_cnt = 0;
    m_empty = 1'b1;
    m_aempty = 1'b1;
    m_dvld = 1'b0;
    m_uf = 1'b0;
    pipe.delete();
    for (int i = 0; i < SS; i++) pipe.push_back(0);
  endtask

  // Drive one cycle's inputs, queue what the DUT must show now, then advance the model
  // across the coming edge.
  task automatic cycle(input bit rn, input bit r, input int w);
    exp_t e;
    int vis;
    bit acc;
    @(posedge clk);
    #2;
    cyc++;
    wr = rn ? w : 0;
    reset_n = rn;
    re = r;
    wptr_gray_in = gray(wr);
    if (rn) assert ($countones(wptr_gray_in ^ prev_g) <= 1);
    prev_g = wptr_gray_in;

    acc = r && !m_empty && rn;
    e.cyc = cyc;
    e.mem_re = acc;
    e.raddr = AW'(m_reads % (1 << AW));
    e.empty = m_empty;
    e.aempty = m_aempty;
    e.rd_cnt = PW'(m_cnt);
    e.rptr_gray = gray(m_reads);
    e.dvld = m_dvld;
    e.uf = m_uf;
    sb.push_back(e);

    if (!rn) begin
      reset_model();
    end else begin
      m_uf = r && m_empty;
      m_dvld = acc;
      m_reads += int'(acc);
      vis = pipe.pop_front();
      pipe.push_back(wr);
      m_cnt = vis - m_reads;
      m_empty = (m_cnt == 0);
      m_aempty = (m_cnt <= AEV);
    end
  endtask

  initial begin
    bit r;
    int w;
    reset_n = 1'b0;
    re = 1'b1;
    wptr_gray_in = '0;
    reset_model();

    // Reset held with a read request pending.
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(1, 0, 0);

    // First write becomes visible SYNC_STAGES+1 edges after it is presented.
    cycle(1, 0, 1);
    repeat (3) cycle(1, 0, 1);

    // Fill to depth, then drain past empty.
    for (int i = 2; i <= 8; i++) cycle(1, 0, i);
    repeat (3) cycle(1, 0, 8);
    repeat (9) cycle(1, 1, 8);
    cycle(1, 0, 8);

    // Random mixed traffic; pointers wrap several times.
    for (int k = 0; k < 300; k++) begin
      r = ($urandom_range(0, 9) < 6);
      w = wr;
      if ((wr + 1 - m_reads <= 8) && ($urandom_range(0, 1) == 1)) w = wr + 1;
      cycle(1, r, w);
    end

    // Read on the same edge a synchronized write lands, with rd_cnt at 3.
    cycle(0, 0, 0);
    for (int i = 1; i <= 3; i++) cycle(1, 0, i);
    repeat (3) cycle(1, 0, 3);
    cycle(1, 0, 4);
    cycle(1, 0, 4);
    cycle(1, 1, 4);
    repeat (3) cycle(1, 0, 4);

    // Reset in the middle of reading a five-entry FIFO.
    cycle(0, 0, 0);
    for (int i = 1; i <= 5; i++) cycle(1, 0, i);
    repeat (3) cycle(1, 0, 5);
    cycle(1, 1, 5);
    cycle(0, 1, 0);
    cycle(1, 1, 0);
    cycle(1, 0, 0);

    @(posedge clk);
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
